// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, NOP encoding,
// the {pc, instr} fetch packet and a counter-width helper.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    // Canonical RV32 NOP (addi x0, x0, 0)
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

    // Counters must be able to hold the value DEPTH itself, hence one extra bit
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Single-clock FIFO with synchronous flush and a combinational head.
// Simultaneous push and pop are accepted even when full, so throughput is
// not lost at the occupancy limit.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    import fetch_unit_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    // Accept/issue qualification; a pop frees the slot a same-cycle push needs
    always_comb begin
        do_pop  = pop && (cnt != '0);
        do_push = push && ((cnt != CW'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy update; flush discards everything immediately
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + CW'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    // Storage array; contents are only meaningful between rd_ptr and wr_ptr
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr];
    assign count     = cnt;
    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one request per cycle from pc_value,
// pairs in-order responses with their fetch address, buffers them for decode
// and throws away responses belonging to the wrong path after a redirect.
module fetch_unit #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned XLEN  = fetch_unit_pkg::XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_value,
    input  logic             redirect,
    output logic             stall,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [XLEN-1:0]  if_instr,
    output logic [XLEN-1:0]  if_pc
);
    import fetch_unit_pkg::*;

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned OW = CW + 1;
    localparam int unsigned PKTW = 2 * XLEN;

    logic [CW-1:0]   inflight_cnt;
    logic [CW-1:0]   inflight_nxt;
    logic [CW-1:0]   discard_cnt;
    logic [CW-1:0]   discard_nxt;
    logic [OW-1:0]   occupancy;

    logic            fire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            if_pop;

    logic [XLEN-1:0] pcq_head;
    logic [CW-1:0]   pcq_count;
    logic            pcq_empty;
    logic            pcq_full;

    logic [PKTW-1:0] ifq_push_data;
    logic [PKTW-1:0] ifq_head;
    logic [CW-1:0]   ifq_count;
    logic            ifq_empty;
    logic            ifq_full;

    logic            unused_ok;

    // Request side: issue while the total of outstanding plus buffered work fits
    always_comb begin
        occupancy      = OW'(inflight_cnt) + OW'(ifq_count);
        imem_req_valid = !rst && !redirect && (occupancy < OW'(DEPTH));
        fire           = imem_req_valid && imem_req_ready;
        stall          = rst || (!fire && !redirect);
        imem_req_addr  = pc_value;
    end

    // Response side: wrong-path responses are dropped, good ones buffered
    always_comb begin
        rsp_drop      = redirect || (discard_cnt != '0);
        rsp_keep      = imem_rsp_valid && !rsp_drop;
        ifq_push_data = {pcq_head, imem_rsp_data};
    end

    // Decode side: head of the instruction FIFO, blanked during reset
    always_comb begin
        if_valid = !rst && !ifq_empty;
        if_pop   = if_valid && if_ready && !redirect;
        if (rst) begin
            if_pc    = '0;
            if_instr = '0;
        end else begin
            if_pc    = ifq_head[PKTW-1:XLEN];
            if_instr = ifq_head[XLEN-1:0];
        end
    end

    // Next values of the in-flight and discard counters
    always_comb begin
        inflight_nxt = inflight_cnt;
        discard_nxt  = discard_cnt;

        if (fire && !imem_rsp_valid) begin
            inflight_nxt = inflight_cnt + CW'(1);
        end else if (!fire && imem_rsp_valid && (inflight_cnt != '0)) begin
            inflight_nxt = inflight_cnt - CW'(1);
        end

        // Everything still outstanding after this cycle belongs to the old path
        if (redirect) begin
            if (imem_rsp_valid && (inflight_cnt != '0)) begin
                discard_nxt = inflight_cnt - CW'(1);
            end else begin
                discard_nxt = inflight_cnt;
            end
        end else if (imem_rsp_valid && (discard_cnt != '0)) begin
            discard_nxt = discard_cnt - CW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_cnt <= '0;
            discard_cnt  <= '0;
        end else begin
            inflight_cnt <= inflight_nxt;
            discard_cnt  <= discard_nxt;
        end
    end

    // Addresses of issued requests, retired by every response kept or not
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (fire),
        .push_data (pc_value),
        .pop       (imem_rsp_valid),
        .head_data (pcq_head),
        .count     (pcq_count),
        .empty     (pcq_empty),
        .full      (pcq_full)
    );

    // {pc, instr} packets waiting for decode
    sync_fifo #(
        .WIDTH (PKTW),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (rsp_keep),
        .push_data (ifq_push_data),
        .pop       (if_pop),
        .head_data (ifq_head),
        .count     (ifq_count),
        .empty     (ifq_empty),
        .full      (ifq_full)
    );

    // PC FIFO occupancy mirrors inflight_cnt; status flags are informational
    assign unused_ok = ^{pcq_count, pcq_empty, pcq_full, ifq_full};

endmodule
